// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and pick logic for the N-port memory arbiter
package mem_arb_pkg;

  localparam int MAX_PORTS = 32;
  localparam int MAX_IDX_W = 5;

  typedef struct packed {
    logic                 valid;
    logic [MAX_IDX_W-1:0] idx;
  } pick_t;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // First requester at or after ptr, wrapping at n; ptr=0 gives fixed priority.
  function automatic pick_t rr_pick(input logic [MAX_PORTS-1:0] req,
                                    input logic [MAX_IDX_W-1:0] ptr,
                                    input int n);
    pick_t p;
    int    k;
    p = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (i < n && !p.valid) begin
        k = int'(ptr) + i;
        if (k >= n) k = k - n;
        if (req[k[MAX_IDX_W-1:0]]) begin
          p.valid = 1'b1;
          p.idx   = k[MAX_IDX_W-1:0];
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mem_arb_tracker.sv
// rtl/mem_arb_tracker.sv - in-order FIFO of port indices for outstanding transfers
module mem_arb_tracker #(
  parameter int W     = 1,
  parameter int DEPTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    push_i,
  input  logic [W-1:0]            data_i,
  input  logic                    pop_i,
  output logic [W-1:0]            head_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty_o = (count_o == '0);
  assign full_o  = (count_o == CW'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot a push needs when full.
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count_o <= count_o + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/mem_arbiter_nport.sv
// rtl/mem_arbiter_nport.sv - N-port OBI-style arbiter onto one memory port with in-order response steering
module mem_arbiter_nport
  import mem_arb_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int MEM_W   = 32,
  parameter int DEPTH   = 8,
  parameter int RR_EN   = 0
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [N_PORTS-1:0]          req_i,
  output logic [N_PORTS-1:0]          gnt_o,
  input  logic [N_PORTS*32-1:0]       addr_i,
  input  logic [N_PORTS-1:0]          we_i,
  input  logic [N_PORTS*MEM_W/8-1:0]  be_i,
  input  logic [N_PORTS*MEM_W-1:0]    wdata_i,
  output logic [N_PORTS-1:0]          rvalid_o,
  output logic [MEM_W-1:0]            rdata_o,
  output logic [N_PORTS-1:0]          err_o,
  output logic                        mem_req_o,
  input  logic                        mem_gnt_i,
  output logic [31:0]                 mem_addr_o,
  output logic                        mem_we_o,
  output logic [MEM_W/8-1:0]          mem_be_o,
  output logic [MEM_W-1:0]            mem_wdata_o,
  input  logic                        mem_rvalid_i,
  input  logic                        mem_err_i,
  input  logic [MEM_W-1:0]            mem_rdata_i,
  output logic [$clog2(DEPTH):0]      outstanding_o,
  output logic                        spurious_o
);
  localparam int IDX_W = idx_w(N_PORTS);
  localparam int BE_W  = MEM_W / 8;

  logic [IDX_W-1:0]     rr_ptr, winner, head;
  logic [MAX_PORTS-1:0] req_ext;
  logic [MAX_IDX_W-1:0] ptr_ext;
  pick_t                pick;
  logic                 full, empty, accept, pop;
  logic                 unused_pick_bits;

  always_comb begin
    req_ext = '0;
    for (int i = 0; i < N_PORTS; i++) req_ext[i] = req_i[i];
    ptr_ext = '0;
    if (RR_EN != 0) ptr_ext[IDX_W-1:0] = rr_ptr;
    pick   = rr_pick(req_ext, ptr_ext, N_PORTS);
    winner = pick.idx[IDX_W-1:0];
  end
  assign unused_pick_bits = ^pick.idx;

  assign mem_req_o = pick.valid & (~full | mem_rvalid_i);
  assign accept    = mem_req_o & mem_gnt_i;
  assign pop       = mem_rvalid_i & ~empty;
  assign rdata_o   = mem_rdata_i;

  always_comb begin
    mem_addr_o  = addr_i[31:0];
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    gnt_o       = '0;
    rvalid_o    = '0;
    err_o       = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (pick.valid && winner == IDX_W'(i)) begin
        mem_addr_o  = addr_i[i*32 +: 32];
        mem_we_o    = we_i[i];
        mem_be_o    = be_i[i*BE_W +: BE_W];
        mem_wdata_o = wdata_i[i*MEM_W +: MEM_W];
        gnt_o[i]    = accept;
      end
      if (head == IDX_W'(i)) begin
        rvalid_o[i] = pop;
        err_o[i]    = pop & mem_err_i;
      end
    end
  end

  mem_arb_tracker #(
    .W     (IDX_W),
    .DEPTH (DEPTH)
  ) u_tracker (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (accept),
    .data_i  (winner),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (outstanding_o)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr     <= '0;
      spurious_o <= 1'b0;
    end else begin
      if (accept && RR_EN != 0)
        rr_ptr <= (winner == IDX_W'(N_PORTS - 1)) ? '0 : winner + 1'b1;
      if (mem_rvalid_i && empty) spurious_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_nport.sv
// tb/tb_mem_arbiter_nport.sv - randomized bench for fixed and round-robin arbiters against a queue model
module tb_mem_arbiter_nport;
  localparam int N     = 3;
  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [2:0]  req_i, we_i;
  logic [95:0] addr_i, wdata_i;
  logic [11:0] be_i;
  logic        mem_gnt_i, mem_rvalid_i, mem_err_i;
  logic [31:0] mem_rdata_i;

  logic [2:0]  f_gnt, f_rvalid, f_err, r_gnt, r_rvalid, r_err;
  logic [31:0] f_rdata, f_addr, f_wdata, r_rdata, r_addr, r_wdata;
  logic        f_mreq, f_we, f_spur, r_mreq, r_we, r_spur;
  logic [3:0]  f_be, r_be;
  logic [2:0]  f_out, r_out;

  int checks = 0;
  int errors = 0;
  int q_fix[$];
  int q_rr[$];
  int rr_ptr = 0;
  bit spur   = 0;

  always #5 clk_i = ~clk_i;

  mem_arbiter_nport #(.N_PORTS(N), .MEM_W(32), .DEPTH(DEPTH), .RR_EN(0)) u_fix (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(f_gnt), .addr_i(addr_i),
    .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(f_rvalid), .rdata_o(f_rdata),
    .err_o(f_err), .mem_req_o(f_mreq), .mem_gnt_i(mem_gnt_i), .mem_addr_o(f_addr),
    .mem_we_o(f_we), .mem_be_o(f_be), .mem_wdata_o(f_wdata), .mem_rvalid_i(mem_rvalid_i),
    .mem_err_i(mem_err_i), .mem_rdata_i(mem_rdata_i), .outstanding_o(f_out), .spurious_o(f_spur));

  mem_arbiter_nport #(.N_PORTS(N), .MEM_W(32), .DEPTH(DEPTH), .RR_EN(1)) u_rr (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(r_gnt), .addr_i(addr_i),
    .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(r_rvalid), .rdata_o(r_rdata),
    .err_o(r_err), .mem_req_o(r_mreq), .mem_gnt_i(mem_gnt_i), .mem_addr_o(r_addr),
    .mem_we_o(r_we), .mem_be_o(r_be), .mem_wdata_o(r_wdata), .mem_rvalid_i(mem_rvalid_i),
    .mem_err_i(mem_err_i), .mem_rdata_i(mem_rdata_i), .outstanding_o(r_out), .spurious_o(r_spur));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int pick_fixed(input logic [2:0] rq);
    for (int i = 0; i < N; i++) if (rq[i]) return i;
    return -1;
  endfunction

  function automatic int pick_rr(input logic [2:0] rq, input int ptr);
    for (int off = 0; off < N; off++) if (rq[(ptr + off) % N]) return (ptr + off) % N;
    return -1;
  endfunction

  task automatic check_dut(input string nm, input int win, input int hd, input bit acc,
                           input logic [2:0] gnt, input logic [2:0] rv, input logic [2:0] er,
                           input logic mreq, input logic [31:0] maddr, input logic mwe,
                           input logic [3:0] mbe, input logic [31:0] mwd, input logic [31:0] rd,
                           input logic [2:0] outst, input logic sp, input bit exp_mreq);
    logic [2:0] e_gnt, e_rv, e_er;
    e_gnt = (acc && win >= 0) ? 3'(1 << win) : 3'b000;
    e_rv  = (hd >= 0) ? 3'(1 << hd) : 3'b000;
    e_er  = (hd >= 0 && mem_err_i) ? 3'(1 << hd) : 3'b000;
    check_eq({nm, ".mem_req"}, mreq, exp_mreq);
    check_eq({nm, ".gnt"}, gnt, e_gnt);
    check_eq({nm, ".addr"}, maddr, (win >= 0) ? addr_i[32*win +: 32] : addr_i[31:0]);
    check_eq({nm, ".we"}, mwe, (win >= 0) ? we_i[win] : 1'b0);
    check_eq({nm, ".be"}, mbe, (win >= 0) ? be_i[4*win +: 4] : 4'h0);
    check_eq({nm, ".wdata"}, mwd, (win >= 0) ? wdata_i[32*win +: 32] : 32'h0);
    check_eq({nm, ".rvalid"}, rv, e_rv);
    check_eq({nm, ".err"}, er, e_er);
    check_eq({nm, ".rdata"}, rd, mem_rdata_i);
    check_eq({nm, ".outstanding"}, outst, q_fix.size());
    check_eq({nm, ".spurious"}, sp, spur);
  endtask

  task automatic step(input bit rst, input logic [2:0] rq, input bit g, input bit rv, input bit er);
    int  wf, wr, hf, hr;
    bit  emreq, acc;
    @(negedge clk_i);
    rst_ni       = ~rst;
    req_i        = rq;
    mem_gnt_i    = g;
    mem_rvalid_i = rv;
    mem_err_i    = er;
    addr_i       = {$urandom, $urandom, $urandom};
    wdata_i      = {$urandom, $urandom, $urandom};
    be_i         = 12'($urandom);
    we_i         = 3'($urandom);
    mem_rdata_i  = $urandom;
    #1;
    emreq = (rq != 0) && (q_fix.size() < DEPTH || rv);
    acc   = emreq && g;
    wf    = pick_fixed(rq);
    wr    = pick_rr(rq, rr_ptr);
    hf    = (rv && q_fix.size() > 0) ? q_fix[0] : -1;
    hr    = (rv && q_rr.size() > 0) ? q_rr[0] : -1;
    check_dut("fix", wf, hf, acc, f_gnt, f_rvalid, f_err, f_mreq, f_addr, f_we, f_be, f_wdata,
              f_rdata, f_out, f_spur, emreq);
    check_dut("rr", wr, hr, acc, r_gnt, r_rvalid, r_err, r_mreq, r_addr, r_we, r_be, r_wdata,
              r_rdata, r_out, r_spur, emreq);
    if (rst) begin
      q_fix.delete();
      q_rr.delete();
      rr_ptr = 0;
      spur   = 0;
    end else begin
      if (rv) begin
        if (q_fix.size() == 0) spur = 1;
        else begin
          void'(q_fix.pop_front());
          void'(q_rr.pop_front());
        end
      end
      if (acc) begin
        q_fix.push_back(wf);
        q_rr.push_back(wr);
        rr_ptr = (wr + 1) % N;
      end
    end
  endtask

  initial begin
    rst_ni = 1'b0; req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; be_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = '0;
    repeat (2) @(posedge clk_i);
    step(1, 3'b000, 0, 0, 0);
    repeat (2) step(0, 3'b000, 0, 0, 0);
    step(0, 3'b000, 0, 1, 0);
    repeat (3) step(0, 3'b000, 0, 0, 0);
    step(1, 3'b000, 0, 0, 0);
    step(0, 3'b000, 0, 0, 0);
    repeat (5) step(0, 3'b111, 1, 0, 0);
    step(0, 3'b111, 1, 1, 0);
    repeat (3) step(0, 3'b111, 0, 0, 0);
    repeat (4) step(0, 3'b000, 0, 1, 0);
    repeat (6) step(0, 3'b111, 1, 1, 0);
    repeat (4) step(0, 3'b000, 0, 1, 0);
    step(0, 3'b010, 1, 0, 0);
    step(0, 3'b001, 1, 0, 0);
    step(0, 3'b010, 1, 0, 0);
    step(0, 3'b000, 0, 1, 0);
    step(0, 3'b000, 0, 1, 1);
    step(0, 3'b000, 0, 1, 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 199) == 0, 3'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0, 1'($urandom));
    repeat (3) step(0, 3'b111, 1, 0, 0);
    step(1, 3'b000, 0, 0, 0);
    repeat (2) step(0, 3'b000, 0, 1, 0);
    step(0, 3'b000, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
